axi_flat_cut_limiter: RTL and testbench

//  Parametrised flat-port AXI4 pass-through for cocotb benches and SoC edges: flat slave port in, flat master port out.
//  Per-channel optional skid-buffer cuts (timing break) plus per-direction outstanding-transaction limiter.

---
 rtl/axi_flat_cut_limiter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_axi_flat_cut_limiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_flat_cut_limiter.sv
// axi_flat_cut_limiter: flat-port AXI4 pass-through with per-channel optional
// skid-buffer cuts and per-direction outstanding-transaction limiters.
// Optional feature macro: AXI_FLAT_CUT_PERF_EN adds rd_beats_o / wr_beats_o
// beat counters for the master-side R and W channels.

// Two-entry skid buffer: registered ready, one cycle latency, full throughput.
module axi_flat_cut_skid #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_chan_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_chan_o,
  output logic         empty_o
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         r_in_ready;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_count_nxt;

  assign w_push = in_valid_i & in_ready_o;
  assign w_pop  = out_valid_o & out_ready_i;

  // Next occupancy, used to register ready one cycle ahead.
  always_comb begin
    // NOTE: default assignment first so no path leaves the variable unassigned (no latch).
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 2'd1;
    else if (w_pop && !w_push) w_count_nxt = r_count - 2'd1;
  end

  // Pointers, occupancy and registered ready.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
    end
  end

  // Payload storage.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; occupancy alone decides what is valid.
    if (w_push) r_mem[r_wr_ptr] <= in_chan_i;
  end

  assign in_ready_o  = r_in_ready & ~rst_i;
  assign out_valid_o = (r_count != 2'd0) & ~rst_i;
  assign out_chan_o  = r_mem[r_rd_ptr];
  assign empty_o     = (r_count == 2'd0);

endmodule

module axi_flat_cut_limiter #(
  parameter int          ADDR_WIDTH  = 64,
  parameter int          DATA_WIDTH  = 64,
  parameter int          ID_WIDTH    = 4,
  parameter int          MAX_RD_TXNS = 8,
  parameter int          MAX_WR_TXNS = 8,
  parameter logic [4:0]  CUT_MASK    = 5'h1F,
  localparam int AWC   = ID_WIDTH + ADDR_WIDTH + 8 + 3,
  localparam int WC    = DATA_WIDTH + DATA_WIDTH / 8 + 1,
  localparam int BC    = ID_WIDTH + 2,
  localparam int RC    = ID_WIDTH + DATA_WIDTH + 2 + 1,
  localparam int RD_CW = $clog2(MAX_RD_TXNS + 1),
  localparam int WR_CW = $clog2(MAX_WR_TXNS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_aw_valid_i,
  output logic             s_aw_ready_o,
  input  logic [AWC-1:0]   s_aw_chan_i,
  input  logic             s_w_valid_i,
  output logic             s_w_ready_o,
  input  logic [WC-1:0]    s_w_chan_i,
  output logic             s_b_valid_o,
  input  logic             s_b_ready_i,
  output logic [BC-1:0]    s_b_chan_o,
  input  logic             s_ar_valid_i,
  output logic             s_ar_ready_o,
  input  logic [AWC-1:0]   s_ar_chan_i,
  output logic             s_r_valid_o,
  input  logic             s_r_ready_i,
  output logic [RC-1:0]    s_r_chan_o,
  output logic             m_aw_valid_o,
  input  logic             m_aw_ready_i,
  output logic [AWC-1:0]   m_aw_chan_o,
  output logic             m_w_valid_o,
  input  logic             m_w_ready_i,
  output logic [WC-1:0]    m_w_chan_o,
  input  logic             m_b_valid_i,
  output logic             m_b_ready_o,
  input  logic [BC-1:0]    m_b_chan_i,
  output logic             m_ar_valid_o,
  input  logic             m_ar_ready_i,
  output logic [AWC-1:0]   m_ar_chan_o,
  input  logic             m_r_valid_i,
  output logic             m_r_ready_o,
  input  logic [RC-1:0]    m_r_chan_i,
  output logic [RD_CW-1:0] rd_outstanding_o,
  output logic [WR_CW-1:0] wr_outstanding_o,
  output logic             idle_o,
`ifdef AXI_FLAT_CUT_PERF_EN
  output logic [31:0]      rd_beats_o,
  output logic [31:0]      wr_beats_o,
`endif
  output logic             err_o
);

  localparam logic [RD_CW-1:0] RD_MAX = RD_CW'(MAX_RD_TXNS);
  localparam logic [WR_CW-1:0] WR_MAX = WR_CW'(MAX_WR_TXNS);

  logic [RD_CW-1:0] r_rd_cnt;
  logic [WR_CW-1:0] r_wr_cnt;
  logic             r_err;
  logic             w_aw_valid, w_aw_ready, w_ar_valid, w_ar_ready;
  logic             w_aw_empty, w_w_empty, w_b_empty, w_ar_empty, w_r_empty;
  logic             w_rd_full, w_wr_full;
  logic             w_rd_inc, w_rd_dec, w_wr_inc, w_wr_dec;

  // AW: slave -> (cut) -> write limiter gate -> master.
  if (CUT_MASK[0]) begin : g_aw_cut
    axi_flat_cut_skid #(.W(AWC)) u_aw (
      .clk_i, .rst_i,
      .in_valid_i(s_aw_valid_i), .in_ready_o(s_aw_ready_o), .in_chan_i(s_aw_chan_i),
      .out_valid_o(w_aw_valid), .out_ready_i(w_aw_ready), .out_chan_o(m_aw_chan_o),
      .empty_o(w_aw_empty));
  end else begin : g_aw_wire
    assign w_aw_valid   = s_aw_valid_i & ~rst_i;
    assign s_aw_ready_o = w_aw_ready & ~rst_i;
    assign m_aw_chan_o  = s_aw_chan_i;
    assign w_aw_empty   = 1'b1;
  end

  // W: slave -> (cut) -> master, never limited.
  if (CUT_MASK[1]) begin : g_w_cut
    axi_flat_cut_skid #(.W(WC)) u_w (
      .clk_i, .rst_i,
      .in_valid_i(s_w_valid_i), .in_ready_o(s_w_ready_o), .in_chan_i(s_w_chan_i),
      .out_valid_o(m_w_valid_o), .out_ready_i(m_w_ready_i), .out_chan_o(m_w_chan_o),
      .empty_o(w_w_empty));
  end else begin : g_w_wire
    assign m_w_valid_o = s_w_valid_i & ~rst_i;
    assign s_w_ready_o = m_w_ready_i & ~rst_i;
    assign m_w_chan_o  = s_w_chan_i;
    assign w_w_empty   = 1'b1;
  end

  // B: master -> (cut) -> slave.
  if (CUT_MASK[2]) begin : g_b_cut
    axi_flat_cut_skid #(.W(BC)) u_b (
      .clk_i, .rst_i,
      .in_valid_i(m_b_valid_i), .in_ready_o(m_b_ready_o), .in_chan_i(m_b_chan_i),
      .out_valid_o(s_b_valid_o), .out_ready_i(s_b_ready_i), .out_chan_o(s_b_chan_o),
      .empty_o(w_b_empty));
  end else begin : g_b_wire
    assign s_b_valid_o = m_b_valid_i & ~rst_i;
    assign m_b_ready_o = s_b_ready_i & ~rst_i;
    assign s_b_chan_o  = m_b_chan_i;
    assign w_b_empty   = 1'b1;
  end

  // AR: slave -> (cut) -> read limiter gate -> master.
  if (CUT_MASK[3]) begin : g_ar_cut
    axi_flat_cut_skid #(.W(AWC)) u_ar (
      .clk_i, .rst_i,
      .in_valid_i(s_ar_valid_i), .in_ready_o(s_ar_ready_o), .in_chan_i(s_ar_chan_i),
      .out_valid_o(w_ar_valid), .out_ready_i(w_ar_ready), .out_chan_o(m_ar_chan_o),
      .empty_o(w_ar_empty));
  end else begin : g_ar_wire
    assign w_ar_valid   = s_ar_valid_i & ~rst_i;
    assign s_ar_ready_o = w_ar_ready & ~rst_i;
    assign m_ar_chan_o  = s_ar_chan_i;
    assign w_ar_empty   = 1'b1;
  end

  // R: master -> (cut) -> slave.
  if (CUT_MASK[4]) begin : g_r_cut
    axi_flat_cut_skid #(.W(RC)) u_r (
      .clk_i, .rst_i,
      .in_valid_i(m_r_valid_i), .in_ready_o(m_r_ready_o), .in_chan_i(m_r_chan_i),
      .out_valid_o(s_r_valid_o), .out_ready_i(s_r_ready_i), .out_chan_o(s_r_chan_o),
      .empty_o(w_r_empty));
  end else begin : g_r_wire
    assign s_r_valid_o = m_r_valid_i & ~rst_i;
    assign m_r_ready_o = s_r_ready_i & ~rst_i;
    assign s_r_chan_o  = m_r_chan_i;
    assign w_r_empty   = 1'b1;
  end

  // Limiter gates: a counter only rises on its own handshake, so a presented
  // request can never be withdrawn by the gate.
  assign w_rd_full    = (r_rd_cnt == RD_MAX);
  assign w_wr_full    = (r_wr_cnt == WR_MAX);
  assign m_ar_valid_o = w_ar_valid & ~w_rd_full;
  assign w_ar_ready   = m_ar_ready_i & ~w_rd_full;
  assign m_aw_valid_o = w_aw_valid & ~w_wr_full;
  assign w_aw_ready   = m_aw_ready_i & ~w_wr_full;

  assign w_rd_inc = m_ar_valid_o & m_ar_ready_i;
  assign w_rd_dec = m_r_valid_i & m_r_ready_o & m_r_chan_i[0];
  assign w_wr_inc = m_aw_valid_o & m_aw_ready_i;
  assign w_wr_dec = m_b_valid_i & m_b_ready_o;

  // Outstanding counters and sticky underflow error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_rd_inc && !w_rd_dec)                          r_rd_cnt <= r_rd_cnt + RD_CW'(1);
      else if (w_rd_dec && !w_rd_inc && r_rd_cnt != '0)   r_rd_cnt <= r_rd_cnt - RD_CW'(1);
      if (w_wr_inc && !w_wr_dec)                          r_wr_cnt <= r_wr_cnt + WR_CW'(1);
      else if (w_wr_dec && !w_wr_inc && r_wr_cnt != '0)   r_wr_cnt <= r_wr_cnt - WR_CW'(1);
      if ((w_rd_dec && r_rd_cnt == '0) || (w_wr_dec && r_wr_cnt == '0)) r_err <= 1'b1;
    end
  end

`ifdef AXI_FLAT_CUT_PERF_EN
  logic [31:0] r_rd_beats;
  logic [31:0] r_wr_beats;

  // Free-running beat counters for master-side R and W; wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_beats <= 32'd0;
      r_wr_beats <= 32'd0;
    end else begin
      if (m_r_valid_i && m_r_ready_o) r_rd_beats <= r_rd_beats + 32'd1;
      if (m_w_valid_o && m_w_ready_i) r_wr_beats <= r_wr_beats + 32'd1;
    end
  end

  assign rd_beats_o = r_rd_beats;
  assign wr_beats_o = r_wr_beats;
`endif

  assign rd_outstanding_o = r_rd_cnt;
  assign wr_outstanding_o = r_wr_cnt;
  assign err_o            = r_err;
  assign idle_o           = (r_rd_cnt == '0) && (r_wr_cnt == '0) && w_aw_empty && w_w_empty &&
                            w_b_empty && w_ar_empty && w_r_empty;

endmodule

// File: tb/tb_axi_flat_cut_limiter.sv
// Self-checking bench for axi_flat_cut_limiter. Instance a: all channels cut,
// MAX_RD_TXNS=2. Instance b: all channels uncut (zero-latency W stream).
module tb_axi_flat_cut_limiter;

  localparam int AW_ = 32;
  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int AWC = IW + AW_ + 8 + 3;
  localparam int WC  = DW + DW / 8 + 1;
  localparam int BC  = IW + 2;
  localparam int RC  = IW + DW + 2 + 1;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_i = ~clk_i;

  // Instance a signals
  logic a_s_aw_valid_i, a_s_aw_ready_o, a_s_w_valid_i, a_s_w_ready_o;
  logic a_s_b_valid_o, a_s_b_ready_i, a_s_ar_valid_i, a_s_ar_ready_o;
  logic a_s_r_valid_o, a_s_r_ready_i;
  logic a_m_aw_valid_o, a_m_aw_ready_i, a_m_w_valid_o, a_m_w_ready_i;
  logic a_m_b_valid_i, a_m_b_ready_o, a_m_ar_valid_o, a_m_ar_ready_i;
  logic a_m_r_valid_i, a_m_r_ready_o;
  logic [AWC-1:0] a_s_aw_chan_i, a_s_ar_chan_i, a_m_aw_chan_o, a_m_ar_chan_o;
  logic [WC-1:0]  a_s_w_chan_i, a_m_w_chan_o;
  logic [BC-1:0]  a_s_b_chan_o, a_m_b_chan_i;
  logic [RC-1:0]  a_s_r_chan_o, a_m_r_chan_i;
  logic [1:0]     a_rd_out;
  logic [3:0]     a_wr_out;
  logic           a_idle, a_err;
  logic [31:0]    a_rd_beats, a_wr_beats;

  // Instance b signals
  logic b_s_aw_valid_i, b_s_aw_ready_o, b_s_w_valid_i, b_s_w_ready_o;
  logic b_s_b_valid_o, b_s_b_ready_i, b_s_ar_valid_i, b_s_ar_ready_o;
  logic b_s_r_valid_o, b_s_r_ready_i;
  logic b_m_aw_valid_o, b_m_aw_ready_i, b_m_w_valid_o, b_m_w_ready_i;
  logic b_m_b_valid_i, b_m_b_ready_o, b_m_ar_valid_o, b_m_ar_ready_i;
  logic b_m_r_valid_i, b_m_r_ready_o;
  logic [AWC-1:0] b_s_aw_chan_i, b_s_ar_chan_i, b_m_aw_chan_o, b_m_ar_chan_o;
  logic [WC-1:0]  b_s_w_chan_i, b_m_w_chan_o;
  logic [BC-1:0]  b_s_b_chan_o, b_m_b_chan_i;
  logic [RC-1:0]  b_s_r_chan_o, b_m_r_chan_i;
  logic [3:0]     b_rd_out, b_wr_out;
  logic           b_idle, b_err;
  logic [31:0]    b_rd_beats, b_wr_beats;

  axi_flat_cut_limiter #(
    .ADDR_WIDTH(AW_), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .MAX_RD_TXNS(2), .MAX_WR_TXNS(8), .CUT_MASK(5'h1F)
  ) dut_a (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_aw_valid_i(a_s_aw_valid_i), .s_aw_ready_o(a_s_aw_ready_o), .s_aw_chan_i(a_s_aw_chan_i),
    .s_w_valid_i(a_s_w_valid_i), .s_w_ready_o(a_s_w_ready_o), .s_w_chan_i(a_s_w_chan_i),
    .s_b_valid_o(a_s_b_valid_o), .s_b_ready_i(a_s_b_ready_i), .s_b_chan_o(a_s_b_chan_o),
    .s_ar_valid_i(a_s_ar_valid_i), .s_ar_ready_o(a_s_ar_ready_o), .s_ar_chan_i(a_s_ar_chan_i),
    .s_r_valid_o(a_s_r_valid_o), .s_r_ready_i(a_s_r_ready_i), .s_r_chan_o(a_s_r_chan_o),
    .m_aw_valid_o(a_m_aw_valid_o), .m_aw_ready_i(a_m_aw_ready_i), .m_aw_chan_o(a_m_aw_chan_o),
    .m_w_valid_o(a_m_w_valid_o), .m_w_ready_i(a_m_w_ready_i), .m_w_chan_o(a_m_w_chan_o),
    .m_b_valid_i(a_m_b_valid_i), .m_b_ready_o(a_m_b_ready_o), .m_b_chan_i(a_m_b_chan_i),
    .m_ar_valid_o(a_m_ar_valid_o), .m_ar_ready_i(a_m_ar_ready_i), .m_ar_chan_o(a_m_ar_chan_o),
    .m_r_valid_i(a_m_r_valid_i), .m_r_ready_o(a_m_r_ready_o), .m_r_chan_i(a_m_r_chan_i),
    .rd_outstanding_o(a_rd_out), .wr_outstanding_o(a_wr_out), .idle_o(a_idle),
`ifdef AXI_FLAT_CUT_PERF_EN
    .rd_beats_o(a_rd_beats), .wr_beats_o(a_wr_beats),
`endif
    .err_o(a_err)
  );

  axi_flat_cut_limiter #(
    .ADDR_WIDTH(AW_), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .MAX_RD_TXNS(8), .MAX_WR_TXNS(8), .CUT_MASK(5'h00)
  ) dut_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_aw_valid_i(b_s_aw_valid_i), .s_aw_ready_o(b_s_aw_ready_o), .s_aw_chan_i(b_s_aw_chan_i),
    .s_w_valid_i(b_s_w_valid_i), .s_w_ready_o(b_s_w_ready_o), .s_w_chan_i(b_s_w_chan_i),
    .s_b_valid_o(b_s_b_valid_o), .s_b_ready_i(b_s_b_ready_i), .s_b_chan_o(b_s_b_chan_o),
    .s_ar_valid_i(b_s_ar_valid_i), .s_ar_ready_o(b_s_ar_ready_o), .s_ar_chan_i(b_s_ar_chan_i),
    .s_r_valid_o(b_s_r_valid_o), .s_r_ready_i(b_s_r_ready_i), .s_r_chan_o(b_s_r_chan_o),
    .m_aw_valid_o(b_m_aw_valid_o), .m_aw_ready_i(b_m_aw_ready_i), .m_aw_chan_o(b_m_aw_chan_o),
    .m_w_valid_o(b_m_w_valid_o), .m_w_ready_i(b_m_w_ready_i), .m_w_chan_o(b_m_w_chan_o),
    .m_b_valid_i(b_m_b_valid_i), .m_b_ready_o(b_m_b_ready_o), .m_b_chan_i(b_m_b_chan_i),
    .m_ar_valid_o(b_m_ar_valid_o), .m_ar_ready_i(b_m_ar_ready_i), .m_ar_chan_o(b_m_ar_chan_o),
    .m_r_valid_i(b_m_r_valid_i), .m_r_ready_o(b_m_r_ready_o), .m_r_chan_i(b_m_r_chan_i),
    .rd_outstanding_o(b_rd_out), .wr_outstanding_o(b_wr_out), .idle_o(b_idle),
`ifdef AXI_FLAT_CUT_PERF_EN
    .rd_beats_o(b_rd_beats), .wr_beats_o(b_wr_beats),
`endif
    .err_o(b_err)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    a_s_aw_valid_i = 0; a_s_w_valid_i = 0; a_s_ar_valid_i = 0; a_m_b_valid_i = 0; a_m_r_valid_i = 0;
    a_s_b_ready_i = 1; a_s_r_ready_i = 1; a_m_aw_ready_i = 1; a_m_w_ready_i = 1; a_m_ar_ready_i = 0;
    a_s_aw_chan_i = '0; a_s_w_chan_i = '0; a_s_ar_chan_i = '0; a_m_b_chan_i = '0; a_m_r_chan_i = '0;
    b_s_aw_valid_i = 0; b_s_w_valid_i = 0; b_s_ar_valid_i = 0; b_m_b_valid_i = 0; b_m_r_valid_i = 0;
    b_s_b_ready_i = 1; b_s_r_ready_i = 1; b_m_aw_ready_i = 1; b_m_w_ready_i = 1; b_m_ar_ready_i = 1;
    b_s_aw_chan_i = '0; b_s_w_chan_i = '0; b_s_ar_chan_i = '0; b_m_b_chan_i = '0; b_m_r_chan_i = '0;
    tick(5);
    n_checks++;
    if ({a_s_b_valid_o, a_s_r_valid_o, a_m_aw_valid_o, a_m_w_valid_o, a_m_ar_valid_o} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_valid_a got %b exp 00000",
               {a_s_b_valid_o, a_s_r_valid_o, a_m_aw_valid_o, a_m_w_valid_o, a_m_ar_valid_o});
    end
    n_checks++;
    if ({a_s_aw_ready_o, a_s_w_ready_o, a_s_ar_ready_o, a_m_b_ready_o, a_m_r_ready_o} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_ready_a got %b exp 00000",
               {a_s_aw_ready_o, a_s_w_ready_o, a_s_ar_ready_o, a_m_b_ready_o, a_m_r_ready_o});
    end
    n_checks++;
    if ({b_s_w_ready_o, b_s_aw_ready_o, b_m_w_valid_o, b_m_r_ready_o} !== 4'b0) begin
      n_errors++;
      $display("FAIL reset_uncut_b got %b exp 0000",
               {b_s_w_ready_o, b_s_aw_ready_o, b_m_w_valid_o, b_m_r_ready_o});
    end
    n_checks++;
    if ({a_idle, a_err, a_rd_out, a_wr_out} !== {1'b1, 1'b0, 2'd0, 4'd0}) begin
      n_errors++;
      $display("FAIL reset_status got idle=%b err=%b rd=%0d wr=%0d exp idle=1 err=0 rd=0 wr=0",
               a_idle, a_err, a_rd_out, a_wr_out);
    end
    rst_i = 1'b0;
    n_checks++;
    if (a_s_ar_ready_o !== 1'b0) begin
      n_errors++;
      $display("FAIL release_ready_early got %b exp 0", a_s_ar_ready_o);
    end
    tick();
    n_checks++;
    if ({a_s_aw_ready_o, a_s_w_ready_o, a_s_ar_ready_o, a_m_b_ready_o, a_m_r_ready_o} !== 5'b11111) begin
      n_errors++;
      $display("FAIL release_ready got %b exp 11111",
               {a_s_aw_ready_o, a_s_w_ready_o, a_s_ar_ready_o, a_m_b_ready_o, a_m_r_ready_o});
    end
  endtask

  task automatic test_read_burst;
    logic [AWC-1:0] ar;
    logic [RC-1:0]  r;
    ar = {4'd2, 32'h0000_1000, 8'd3, 3'd2};
    a_s_ar_chan_i = ar;
    a_s_ar_valid_i = 1'b1;
    tick();
    a_s_ar_valid_i = 1'b0;
    n_checks++;
    if ({a_m_ar_valid_o, a_m_ar_chan_o} !== {1'b1, ar}) begin
      n_errors++;
      $display("FAIL ar_latency got v=%b chan=%h exp v=1 chan=%h", a_m_ar_valid_o, a_m_ar_chan_o, ar);
    end
    a_m_ar_ready_i = 1'b1;
    tick();
    n_checks++;
    if (a_rd_out !== 2'd1 || a_m_ar_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL ar_issued got rd=%0d v=%b exp rd=1 v=0", a_rd_out, a_m_ar_valid_o);
    end
    for (int k = 0; k < 4; k++) begin
      r = {4'd2, 32'hA0 + 32'(k), 2'b00, (k == 3)};
      a_m_r_chan_i = r;
      a_m_r_valid_i = 1'b1;
      if (k == 3) begin
        n_checks++;
        if (a_rd_out !== 2'd1) begin
          n_errors++;
          $display("FAIL rd_before_last got %0d exp 1", a_rd_out);
        end
      end
      tick();
      n_checks++;
      if ({a_s_r_valid_o, a_s_r_chan_o} !== {1'b1, r}) begin
        n_errors++;
        $display("FAIL r_beat%0d got v=%b chan=%h exp v=1 chan=%h", k, a_s_r_valid_o, a_s_r_chan_o, r);
      end
    end
    a_m_r_valid_i = 1'b0;
    n_checks++;
    if (a_rd_out !== 2'd0) begin
      n_errors++;
      $display("FAIL rd_after_last got %0d exp 0", a_rd_out);
    end
    tick();
    n_checks++;
    if (a_s_r_valid_o !== 1'b0 || a_idle !== 1'b1) begin
      n_errors++;
      $display("FAIL read_drain got v=%b idle=%b exp v=0 idle=1", a_s_r_valid_o, a_idle);
    end
  endtask

  task automatic test_read_limit;
    logic [AWC-1:0] ar3;
    ar3 = {4'd3, 32'h0000_3000, 8'd0, 3'd2};
    a_m_ar_ready_i = 1'b1;
    a_s_ar_valid_i = 1'b1;
    a_s_ar_chan_i = {4'd1, 32'h0000_1000, 8'd0, 3'd2};
    tick();
    a_s_ar_chan_i = {4'd2, 32'h0000_2000, 8'd0, 3'd2};
    tick();
    a_s_ar_chan_i = ar3;
    tick();
    n_checks++;
    if (a_m_ar_valid_o !== 1'b0 || a_rd_out !== 2'd2 || a_s_ar_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL limit_hold got v=%b rd=%0d srdy=%b exp v=0 rd=2 srdy=1",
               a_m_ar_valid_o, a_rd_out, a_s_ar_ready_o);
    end
    a_s_ar_chan_i = {4'd4, 32'h0000_4000, 8'd0, 3'd2};
    tick();
    a_s_ar_valid_i = 1'b0;
    n_checks++;
    if (a_s_ar_ready_o !== 1'b0 || a_m_ar_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL limit_full got srdy=%b v=%b exp srdy=0 v=0", a_s_ar_ready_o, a_m_ar_valid_o);
    end
    a_m_r_chan_i = {4'd1, 32'h0, 2'b00, 1'b1};
    a_m_r_valid_i = 1'b1;
    tick();
    a_m_r_valid_i = 1'b0;
    n_checks++;
    if ({a_m_ar_valid_o, a_m_ar_chan_o, a_rd_out} !== {1'b1, ar3, 2'd1}) begin
      n_errors++;
      $display("FAIL limit_release got v=%b chan=%h rd=%0d exp v=1 chan=%h rd=1",
               a_m_ar_valid_o, a_m_ar_chan_o, a_rd_out, ar3);
    end
    tick();
    n_checks++;
    if (a_m_ar_valid_o !== 1'b0 || a_rd_out !== 2'd2 || a_s_ar_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL limit_rehold got v=%b rd=%0d srdy=%b exp v=0 rd=2 srdy=1",
               a_m_ar_valid_o, a_rd_out, a_s_ar_ready_o);
    end
    a_m_r_valid_i = 1'b1;
    tick(3);
    a_m_r_valid_i = 1'b0;
    n_checks++;
    if (a_rd_out !== 2'd0 || a_err !== 1'b0) begin
      n_errors++;
      $display("FAIL limit_drain got rd=%0d err=%b exp rd=0 err=0", a_rd_out, a_err);
    end
    tick(2);
    n_checks++;
    if (a_idle !== 1'b1) begin
      n_errors++;
      $display("FAIL limit_idle got %b exp 1", a_idle);
    end
  endtask

  task automatic test_wr_same_cycle;
    logic [BC-1:0] b;
    b = {4'd5, 2'b00};
    a_s_aw_chan_i = {4'd5, 32'h0000_2000, 8'd0, 3'd2};
    a_s_aw_valid_i = 1'b1;
    tick();
    a_s_aw_valid_i = 1'b0;
    tick();
    n_checks++;
    if (a_wr_out !== 4'd1) begin
      n_errors++;
      $display("FAIL wr_first got %0d exp 1", a_wr_out);
    end
    a_s_aw_valid_i = 1'b1;
    tick();
    a_s_aw_valid_i = 1'b0;
    a_m_b_chan_i = b;
    a_m_b_valid_i = 1'b1;
    n_checks++;
    if (a_m_aw_valid_o !== 1'b1 || a_m_b_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL wr_setup got awv=%b brdy=%b exp awv=1 brdy=1", a_m_aw_valid_o, a_m_b_ready_o);
    end
    tick();
    n_checks++;
    if ({a_wr_out, a_s_b_valid_o, a_s_b_chan_o} !== {4'd1, 1'b1, b}) begin
      n_errors++;
      $display("FAIL wr_same_cycle got wr=%0d bv=%b b=%h exp wr=1 bv=1 b=%h",
               a_wr_out, a_s_b_valid_o, a_s_b_chan_o, b);
    end
    tick();
    a_m_b_valid_i = 1'b0;
    n_checks++;
    if (a_wr_out !== 4'd0 || a_err !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_complete got wr=%0d err=%b exp wr=0 err=0", a_wr_out, a_err);
    end
    tick(2);
  endtask

  task automatic test_b_error;
    logic [BC-1:0] b;
    b = {4'd7, 2'b10};
    a_m_b_chan_i = b;
    a_m_b_valid_i = 1'b1;
    tick();
    a_m_b_valid_i = 1'b0;
    n_checks++;
    if ({a_s_b_valid_o, a_s_b_chan_o, a_wr_out, a_err} !== {1'b1, b, 4'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL b_underflow got bv=%b b=%h wr=%0d err=%b exp bv=1 b=%h wr=0 err=1",
               a_s_b_valid_o, a_s_b_chan_o, a_wr_out, a_err, b);
    end
    tick(3);
    n_checks++;
    if (a_err !== 1'b1 || a_s_b_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL err_sticky got err=%b bv=%b exp err=1 bv=0", a_err, a_s_b_valid_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_checks++;
    if (a_err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_reset got %b exp 0", a_err);
    end
    tick();
  endtask

  task automatic test_w_uncut;
    logic [WC-1:0] beats [64];
    int  tx = 0;
    int  rx = 0;
    int  cyc = 0;
    logic s_hs;
    for (int i = 0; i < 64; i++) beats[i] = {$urandom(), 4'($urandom_range(0, 15)), (i % 4 == 3)};
    while ((rx < 64 || tx < 64) && cyc < 2000) begin
      cyc++;
      b_m_w_ready_i = ($urandom_range(0, 3) != 0);
      if (!b_s_w_valid_i && tx < 64) b_s_w_valid_i = ($urandom_range(0, 3) != 0);
      b_s_w_chan_i = (tx < 64) ? beats[tx] : '0;
      #1;
      n_checks++;
      if (b_m_w_valid_o !== b_s_w_valid_i || b_s_w_ready_o !== b_m_w_ready_i) begin
        n_errors++;
        $display("FAIL w_zero_latency cyc=%0d got mv=%b srdy=%b exp mv=%b srdy=%b",
                 cyc, b_m_w_valid_o, b_s_w_ready_o, b_s_w_valid_i, b_m_w_ready_i);
      end
      if (b_m_w_valid_o === 1'b1 && b_m_w_ready_i === 1'b1) begin
        n_checks++;
        if (rx >= 64 || b_m_w_chan_o !== beats[rx]) begin
          n_errors++;
          $display("FAIL w_beat%0d got %h exp %h", rx, b_m_w_chan_o, (rx < 64) ? beats[rx] : '0);
        end
        rx++;
      end
      s_hs = b_s_w_valid_i & b_s_w_ready_o;
      tick();
      if (s_hs) begin
        tx++;
        b_s_w_valid_i = 1'b0;
      end
    end
    b_s_w_valid_i = 1'b0;
    n_checks++;
    if (rx != 64 || tx != 64) begin
      n_errors++;
      $display("FAIL w_count got rx=%0d tx=%0d exp rx=64 tx=64", rx, tx);
    end
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_read_limit();
    test_wr_same_cycle();
    test_b_error();
    test_w_uncut();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
